// File: rtl/seq_alu_pkg.sv
// Shared opcode map and FSM encoding for the sequential ALU.
// Opcodes 0000-1000 keep the legacy combinational ALU meaning.
package seq_alu_pkg;

    localparam logic [3:0] OP_ADD     = 4'h0;
    localparam logic [3:0] OP_SUB     = 4'h1;
    localparam logic [3:0] OP_MUL     = 4'h2;
    localparam logic [3:0] OP_DIV     = 4'h3;
    localparam logic [3:0] OP_MOD     = 4'h4;
    localparam logic [3:0] OP_AND     = 4'h5;
    localparam logic [3:0] OP_OR      = 4'h6;
    localparam logic [3:0] OP_XOR     = 4'h7;
    localparam logic [3:0] OP_XNOR    = 4'h8;
    localparam logic [3:0] OP_SHL     = 4'h9;
    localparam logic [3:0] OP_SHR     = 4'hA;
    localparam logic [3:0] OP_ILL_MIN = 4'hB;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DIV  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

endpackage

// File: rtl/seq_alu_div.sv
// Iterative restoring divider: one quotient bit per cycle, W cycles per divide.
// done, quotient and remainder are valid during the final iteration cycle.
module seq_alu_div
    import seq_alu_pkg::*;
#(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [W-1:0] dividend,
    input  logic [W-1:0] divisor,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] quotient,
    output logic [W-1:0] remainder
);

    localparam int unsigned CW = $clog2(W + 1);

    logic [W-1:0]  r_rem;
    logic [W-1:0]  r_quo;
    logic [W-1:0]  r_dvs;
    logic [CW-1:0] r_cnt;
    logic          r_busy;

    logic [W:0]    w_shift;
    logic [W:0]    w_trial;
    logic [W-1:0]  w_rem_nxt;
    logic [W-1:0]  w_quo_nxt;

    // Partial remainder stays below the divisor, so W+1 bits cover the trial subtract.
    always_comb begin
        w_shift = {r_rem, r_quo[W-1]};
        w_trial = w_shift - {1'b0, r_dvs};
        if (w_trial[W]) begin
            w_rem_nxt = w_shift[W-1:0];
            w_quo_nxt = {r_quo[W-2:0], 1'b0};
        end else begin
            w_rem_nxt = w_trial[W-1:0];
            w_quo_nxt = {r_quo[W-2:0], 1'b1};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_rem  <= '0;
            r_quo  <= '0;
            r_dvs  <= '0;
            r_cnt  <= '0;
            r_busy <= 1'b0;
        end else if (start) begin
            r_rem  <= '0;
            r_quo  <= dividend;
            r_dvs  <= divisor;
            r_cnt  <= CW'(W);
            r_busy <= 1'b1;
        end else if (r_busy) begin
            r_rem <= w_rem_nxt;
            r_quo <= w_quo_nxt;
            r_cnt <= r_cnt - CW'(1);
            if (r_cnt == CW'(1)) begin
                r_busy <= 1'b0;
            end
        end
    end

    assign busy      = r_busy;
    assign done      = r_busy && (r_cnt == CW'(1));
    assign quotient  = w_quo_nxt;
    assign remainder = w_rem_nxt;

endmodule

// File: rtl/seq_alu.sv
// Sequential ALU with valid/ready handshakes, multi-cycle divide and status flags.
// Result and flags are registered and held in DONE until the sink takes them.
module seq_alu
    import seq_alu_pkg::*;
#(
    parameter int unsigned W = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [W-1:0]   a,
    input  logic [W-1:0]   b,
    input  logic [3:0]     s,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [2*W-1:0] y,
    output logic           flag_zero,
    output logic           flag_carry,
    output logic           flag_dz,
    output logic           flag_ill
);

    localparam int unsigned SHW = $clog2(W);

    state_e         r_state;
    logic           r_op_mod;
    logic [2*W-1:0] r_y;
    logic           r_zero;
    logic           r_carry;
    logic           r_dz;
    logic           r_ill;
    logic           r_out_valid;

    logic           w_accept;
    logic           w_div_start;
    logic           w_div_busy;
    logic           w_div_done;
    logic [W-1:0]   w_quo;
    logic [W-1:0]   w_rem;
    logic [2*W-1:0] w_a_ext;
    logic [2*W-1:0] w_b_ext;
    logic [2*W-1:0] w_sum;
    logic [2*W-1:0] w_diff;
    logic [2*W-1:0] w_prod;
    logic [2*W-1:0] w_y;
    logic [2*W-1:0] w_div_y;
    logic           w_carry;
    logic           w_dz;
    logic           w_ill;

    assign in_ready    = (r_state == ST_IDLE);
    assign w_accept    = in_valid && in_ready;
    assign w_div_start = w_accept && ((s == OP_DIV) || (s == OP_MOD)) && (b != '0);

    assign w_a_ext = {{W{1'b0}}, a};
    assign w_b_ext = {{W{1'b0}}, b};
    assign w_sum   = w_a_ext + w_b_ext;
    assign w_diff  = w_a_ext - w_b_ext;
    assign w_prod  = w_a_ext * w_b_ext;
    assign w_div_y = r_op_mod ? {{W{1'b0}}, w_rem} : {{W{1'b0}}, w_quo};

    // Single-cycle ops, including the divide-by-zero shortcut, straight from the inputs.
    always_comb begin
        w_y     = '0;
        w_carry = 1'b0;
        w_dz    = 1'b0;
        w_ill   = 1'b0;
        case (s)
            OP_ADD: begin
                w_y     = w_sum;
                w_carry = w_sum[W];
            end
            OP_SUB: begin
                w_y     = w_diff;
                w_carry = (a < b);
            end
            OP_MUL:  w_y = w_prod;
            OP_DIV: begin
                w_y  = {{W{1'b0}}, {W{1'b1}}};
                w_dz = 1'b1;
            end
            OP_MOD: begin
                w_y  = w_a_ext;
                w_dz = 1'b1;
            end
            OP_AND:  w_y = w_a_ext & w_b_ext;
            OP_OR:   w_y = w_a_ext | w_b_ext;
            OP_XOR:  w_y = w_a_ext ^ w_b_ext;
            OP_XNOR: w_y = {{W{1'b0}}, ~(a ^ b)};
            OP_SHL:  w_y = w_a_ext << b[SHW-1:0];
            OP_SHR:  w_y = w_a_ext >> b[SHW-1:0];
            default: w_ill = (s >= OP_ILL_MIN);
        endcase
    end

    seq_alu_div #(
        .W (W)
    ) u_div (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (w_div_start),
        .dividend  (a),
        .divisor   (b),
        .busy      (w_div_busy),
        .done      (w_div_done),
        .quotient  (w_quo),
        .remainder (w_rem)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_op_mod    <= 1'b0;
            r_y         <= '0;
            r_zero      <= 1'b0;
            r_carry     <= 1'b0;
            r_dz        <= 1'b0;
            r_ill       <= 1'b0;
            r_out_valid <= 1'b0;
        end else begin
            unique case (r_state)
                ST_IDLE: begin
                    if (w_div_start) begin
                        r_op_mod <= (s == OP_MOD);
                        r_state  <= ST_DIV;
                    end else if (w_accept) begin
                        r_y         <= w_y;
                        r_zero      <= (w_y == '0);
                        r_carry     <= w_carry;
                        r_dz        <= w_dz;
                        r_ill       <= w_ill;
                        r_out_valid <= 1'b1;
                        r_state     <= ST_DONE;
                    end
                end
                ST_DIV: begin
                    if (w_div_done) begin
                        r_y         <= w_div_y;
                        r_zero      <= (w_div_y == '0);
                        r_carry     <= 1'b0;
                        r_dz        <= 1'b0;
                        r_ill       <= 1'b0;
                        r_out_valid <= 1'b1;
                        r_state     <= ST_DONE;
                    end else if (!w_div_busy) begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_state     <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign out_valid  = r_out_valid;
    assign y          = r_y;
    assign flag_zero  = r_zero;
    assign flag_carry = r_carry;
    assign flag_dz    = r_dz;
    assign flag_ill   = r_ill;

endmodule

// File: tb/tb_seq_alu.sv
// Scoreboard bench for seq_alu (W=8): directed commands push expected results,
// a negedge monitor pops and compares on every output handshake.
module tb_seq_alu;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [7:0]  a = 8'h00;
    logic [7:0]  b = 8'h00;
    logic [3:0]  s = 4'h0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] y;
    logic        flag_zero;
    logic        flag_carry;
    logic        flag_dz;
    logic        flag_ill;

    typedef struct packed {
        logic [15:0] y;
        logic [3:0]  fl;
    } exp_t;

    exp_t  exp_q[$];
    string name_q[$];
    int    n_pass = 0;
    int    n_total = 0;
    int    n_hs = 0;
    int    n_push = 0;

    seq_alu #(
        .W (8)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .a          (a),
        .b          (b),
        .s          (s),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .y          (y),
        .flag_zero  (flag_zero),
        .flag_carry (flag_carry),
        .flag_dz    (flag_dz),
        .flag_ill   (flag_ill)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_total++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, req);
    endtask

    always @(posedge clk) begin
        if (rst_n && out_valid && out_ready) n_hs++;
    end

    always @(negedge clk) begin : mon
        exp_t  e;
        string nm;
        if (rst_n && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                n_total++;
                $display("FAIL spurious_result: got y=0x%0h, expected no result", y);
            end else begin
                e  = exp_q.pop_front();
                nm = name_q.pop_front();
                chk({nm, "_y"}, 32'(y), 32'(e.y));
                chk({nm, "_flags"}, 32'({flag_zero, flag_carry, flag_dz, flag_ill}), 32'(e.fl));
            end
        end
    end

    // Called at #1 after a posedge; returns at #1 after the accept edge.
    task automatic send(input logic [7:0] ta, input logic [7:0] tb_v, input logic [3:0] ts,
                        input logic [15:0] ey, input logic [3:0] efl, input string nm,
                        input bit push);
        int n = 0;
        a = ta;
        b = tb_v;
        s = ts;
        in_valid = 1'b1;
        while (!in_ready && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (!in_ready) begin
            n_total++;
            $display("FAIL %s_accept: in_ready low for 100 cycles, expected high", nm);
            in_valid = 1'b0;
            return;
        end
        if (push) begin
            exp_q.push_back('{ey, efl});
            name_q.push_back(nm);
            n_push++;
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        a = 8'h5A;
        b = 8'h00;
        s = 4'hF;
    endtask

    // lat: sample index of first out_valid (1 = right after accept); busy: in_ready-low samples.
    task automatic measure(output int lat, output int busy);
        bit seen = 1'b0;
        lat  = -1;
        busy = -1;
        for (int k = 1; k <= 60; k++) begin
            if (!seen && out_valid) begin
                lat  = k;
                seen = 1'b1;
            end
            if (in_ready) begin
                busy = k - 1;
                break;
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic op(input logic [7:0] ta, input logic [7:0] tb_v, input logic [3:0] ts,
                      input logic [15:0] ey, input logic [3:0] efl, input string nm,
                      input int lat_exp);
        int lat;
        int busy;
        send(ta, tb_v, ts, ey, efl, nm, 1'b1);
        measure(lat, busy);
        chk({nm, "_lat"}, 32'(lat), 32'(lat_exp));
        chk({nm, "_busy"}, 32'(busy), 32'(lat_exp));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, expected completion");
        $fatal(1);
    end

    initial begin
        int hs_before;
        rst_n     = 1'b0;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_y", 32'(y), 32'd0);
        chk("rst_flags", 32'({flag_zero, flag_carry, flag_dz, flag_ill}), 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // flags nibble = {zero, carry, dz, ill}
        op(8'd200, 8'd100, 4'h0, 16'h012C, 4'b0100, "add", 1);
        op(8'd0,   8'd0,   4'h0, 16'h0000, 4'b1000, "add_zero", 1);
        op(8'd5,   8'd7,   4'h1, 16'hFFFE, 4'b0100, "sub", 1);
        op(8'd255, 8'd255, 4'h2, 16'hFE01, 4'b0000, "mul", 1);
        op(8'd200, 8'd7,   4'h3, 16'd28,   4'b0000, "div", 9);
        op(8'd200, 8'd7,   4'h4, 16'd4,    4'b0000, "mod", 9);
        op(8'd7,   8'd200, 4'h3, 16'd0,    4'b1000, "div_small", 9);
        op(8'd255, 8'd1,   4'h3, 16'd255,  4'b0000, "div_by1", 9);
        op(8'd9,   8'd0,   4'h3, 16'h00FF, 4'b0010, "div0", 1);
        op(8'd9,   8'd0,   4'h4, 16'd9,    4'b0010, "mod0", 1);
        op(8'h00,  8'h00,  4'hC, 16'h0000, 4'b1001, "ill_c", 1);
        op(8'h12,  8'h34,  4'hF, 16'h0000, 4'b1001, "ill_f", 1);
        op(8'hF0,  8'h3C,  4'h5, 16'h0030, 4'b0000, "and", 1);
        op(8'hF0,  8'h0F,  4'h6, 16'h00FF, 4'b0000, "or", 1);
        op(8'hF0,  8'h0F,  4'h8, 16'h0000, 4'b1000, "xnor", 1);
        op(8'h81,  8'h03,  4'h9, 16'h0408, 4'b0000, "shl", 1);
        op(8'h81,  8'h09,  4'hA, 16'h0040, 4'b0000, "shr", 1);

        // Back-pressure: result held, second command ignored while stalled.
        out_ready = 1'b0;
        hs_before = n_hs;
        send(8'd1, 8'd1, 4'h0, 16'd2, 4'b0000, "bp", 1'b1);
        a = 8'd3;
        b = 8'd3;
        s = 4'h0;
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            chk("bp_out_valid", 32'(out_valid), 32'd1);
            chk("bp_y", 32'(y), 32'd2);
            chk("bp_in_ready", 32'(in_ready), 32'd0);
            @(posedge clk);
            #1;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("bp_release_in_ready", 32'(in_ready), 32'd1);
        chk("bp_release_out_valid", 32'(out_valid), 32'd0);
        chk("bp_handshakes", 32'(n_hs), 32'(hs_before + 1));

        // Reset four edges into a divide: no result may appear.
        send(8'd100, 8'd3, 4'h3, 16'd33, 4'b0000, "div_aborted", 1'b0);
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        chk("midrst_in_ready", 32'(in_ready), 32'd1);
        chk("midrst_out_valid", 32'(out_valid), 32'd0);
        chk("midrst_y", 32'(y), 32'd0);
        chk("midrst_flags", 32'({flag_zero, flag_carry, flag_dz, flag_ill}), 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        op(8'hF0, 8'hFF, 4'h7, 16'h000F, 4'b0000, "xor_after_rst", 1);

        repeat (3) @(posedge clk);
        #1;
        chk("queue_empty", 32'(exp_q.size()), 32'd0);
        chk("handshakes", 32'(n_hs), 32'(n_push));
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/seq_alu.md
Name: seq_alu

Overview:
- Parametrised, clocked successor to the team's combinational 8-bit ALU, with the same opcode map for codes 0000-1000.
- Adds: generic operand width, valid/ready handshakes on input and output, iterative multi-cycle divide/modulus, shift ops, status flags, and defined results for illegal opcodes and divide-by-zero.
- Sits between an operand/command source (sequencer or register file) and a result sink.
- Sink may stall; block holds its result until taken.

Parameters:
- W, 8: operand width in bits; legal range 2..32; result width is 2*W.
- SHW, $clog2(W): derived, not overridable; shift-amount width.

Ports:
- clk  in  1  rising-edge clock, sole clock.
- rst_n  in  1  synchronous, active-low reset; sampled on rising clk edge.
- in_valid  in  1  operands/opcode valid.
- in_ready  out  1  block can accept a command.
- a  in  W  operand A, unsigned.
- b  in  W  operand B, unsigned.
- s  in  4  opcode.
- out_valid  out  1  result valid.
- out_ready  in  1  sink accepts result.
- y  out  2*W  result.
- flag_zero  out  1  y == 0.
- flag_carry  out  1  add carry-out / sub borrow; 0 for other ops.
- flag_dz  out  1  div/mod with b == 0.
- flag_ill  out  1  illegal opcode.

Behaviour:
- Reset (rst_n=0 at edge): state=IDLE, out_valid=0, y=0, all flags=0, divider cleared. Reset aborts any in-flight op; no result is emitted for it.
- FSM states: IDLE, DIV, DONE.
  - in_ready = (state==IDLE), combinational from state only.
  - Accept happens when in_valid && in_ready at an edge; a, b, s are captured.
- IDLE transitions on accept:
  - s=0011/0100 with b!=0: go to DIV.
  - Otherwise: compute, register y and flags, go to DONE.
- DIV: one quotient bit per cycle (restoring), W cycles, then register y and flags and go to DONE.
- DONE: out_valid=1. y and flags stay stable until out_ready=1 at an edge, then go to IDLE with out_valid=0.
- Latency, accept edge to first out_valid cycle:
  - Non-divide ops: 1 cycle.
  - Divide/modulus: W+1 cycles.
- Max throughput: one command per 2 cycles, since in_ready is low in DONE.
- Opcodes; all arithmetic is unsigned, computed at 2*W bits and truncated to 2*W:
  - 0000 add: y=a+b zero-extended; flag_carry=bit W of the sum.
  - 0001 sub: y=a-b at 2*W bits (two's-complement wrap when a<b); flag_carry=(a<b).
  - 0010 mul: y=a*b, full 2*W product.
  - 0011 div: y=quotient, zero-extended.
  - 0100 mod: y=remainder, zero-extended.
  - 0101/0110/0111: AND/OR/XOR, zero-extended.
  - 1000 XNOR: y={W zeros, ~(a^b)}.
  - 1001 shl: y=a << b[SHW-1:0], full 2*W.
  - 1010 shr: y=a >> b[SHW-1:0], logical.
  - 1011-1111 illegal: y=0, flag_ill=1, flag_zero=1, 1-cycle latency.
- Divide-by-zero (b=0, s=0011 or 0100):
  - No DIV state; 1-cycle latency; flag_dz=1.
  - div: y={W zeros, W ones}. mod: y=a.
- flag_zero is computed from the final registered y for every op.
- in_valid while in_ready=0 is ignored; the source must hold the command.
- a, b, s changes after the accept edge do not affect the in-flight op.
- out_ready is ignored while out_valid=0.
- rst_n low in DONE with out_ready high: reset wins, no handshake is counted.

Decomposition:
- Shared package (seq_alu_pkg):
  - Opcode localparams OP_ADD..OP_SHR, OP_ILL_MIN.
  - FSM state encoding ST_IDLE/ST_DIV/ST_DONE.
- Sub-module seq_alu_div:
  - Iterative restoring divider, parametrised by W.
  - Ports: clk, rst_n, start, dividend, divisor, busy, done, quotient, remainder.
  - Top-level FSM sequences it; all other ops stay in the top module.

Test Plan (W=8):
1. Reset, then add a=200,b=100, out_ready=1: out_valid exactly 1 cycle after accept; y=300 (0x012C), flag_carry=1, flag_zero=0.
2. Sub a=5,b=7: y=0xFFFE, flag_carry=1. Mul a=255,b=255: y=0xFE01.
3. Div a=200,b=7: in_ready low for 9 cycles after accept, out_valid at accept+9, y=28. Mod same operands: y=4.
4. Div a=9,b=0: 1-cycle latency, y=0x00FF, flag_dz=1. Mod a=9,b=0: y=9, flag_dz=1. Opcode 1100: y=0, flag_ill=1, flag_zero=1.
5. Back-pressure: add a=1,b=1 with out_ready=0 for 5 cycles: out_valid and y=2 held stable, in_ready=0, a second in_valid is not accepted. Raise out_ready: one handshake, then in_ready=1 next cycle.
6. Reset mid-divide: start div a=100,b=3, drop rst_n at accept+4. Next cycle: in_ready=1, out_valid=0, y=0. A following xor a=0xF0,b=0xFF gives y=0x000F.
